// File: rtl/pool_pkg.sv
// Shared definitions for the pooling row feeder.
// Contents: beat geometry (lanes x lane width), config counter width and the FSM state type.
package pool_pkg;

  localparam int unsigned LANES  = 32;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned COL_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StSend,
    StGap
  } state_e;

endpackage

// File: rtl/pool_row_feeder_if.sv
// Beat streams around the row feeder.
//   in_valid/in_ready/in_data : bursty upstream activations (valid/ready)
//   out_valid/out_data/row_end: row-contiguous beats to pooling (no backpressure)
// slave is the feeder side, master is the producer/consumer environment side.
interface pool_row_feeder_if #(
  parameter int unsigned DATA_W = pool_pkg::DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              row_end;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  row_end
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output row_end
  );

endinterface

// File: rtl/pool_feed_fifo.sv
// Synchronous FIFO holding activation beats until a full row is available.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (flushes pointers/count)
//   wr_en, wr_data    : push one beat
//   rd_en, rd_data    : pop head; rd_data is registered and holds between pops
//   count, full, empty: occupancy (log2(DEPTH)+1 bits) and flags
module pool_feed_fifo #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [DATA_W-1:0] rd_data_q;

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/pool_row_feeder.sv
// Row-alignment buffer in front of the pooling stage. Collects bursty beats and re-emits each
// row as exactly cfg_col back-to-back beats, followed by at least GAP+1 idle cycles.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle frame start; cfg_col/cfg_rows sampled here
//   cfg_col, cfg_rows    : beats per row, rows per frame
//   stream (slave)       : in_valid/in_ready/in_data and out_valid/out_data/row_end
//   frame_done           : pulse the cycle after the last row's gap
//   busy                 : frame in progress
//   cfg_err              : sticky bad-config flag, cleared by the next accepted start
module pool_row_feeder #(
  parameter int unsigned DATA_W = pool_pkg::DATA_W,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned GAP    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             cfg_col,
  input  logic [15:0]             cfg_rows,
  pool_row_feeder_if.slave        stream,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    cfg_err
);

  import pool_pkg::*;

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP - 1);
  localparam logic [COL_W-1:0] DepthCol = COL_W'(DEPTH);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_r_q, col_r_d;
  logic [COL_W-1:0]   rows_r_q, rows_r_d;
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic [COL_W-1:0]   row_cnt_q, row_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               cfg_err_q, cfg_err_d;
  logic               out_valid_q, row_end_q, frame_done_q;
  logic               frame_done_d;
  logic               rd_en, wr_en;
  logic               col_last;

  logic [$clog2(DEPTH):0] fifo_count;
  logic [COL_W-1:0]       fifo_count_ext;
  logic                   fifo_full, fifo_empty;

  assign busy           = (state_q != StIdle);
  // in_ready depends on registers only, never on in_valid.
  assign stream.in_ready = busy && !fifo_full;
  assign wr_en          = stream.in_valid && stream.in_ready;
  assign fifo_count_ext = COL_W'(fifo_count);
  assign col_last       = (col_cnt_q == col_r_q - 16'd1);

  pool_feed_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (stream.in_data),
    .rd_en   (rd_en),
    .rd_data (stream.out_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    col_r_d      = col_r_q;
    rows_r_d     = rows_r_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cfg_err_d    = cfg_err_q;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_col == '0 || cfg_col > DepthCol || cfg_rows == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            col_r_d   = cfg_col;
            rows_r_d  = cfg_rows;
            cfg_err_d = 1'b0;
            col_cnt_d = '0;
            row_cnt_d = '0;
            state_d   = StFill;
          end
        end
      end
      StFill: begin
        // Registered count only: a same-cycle write is seen next cycle.
        if (fifo_count_ext >= col_r_q) begin
          state_d = StSend;
        end
      end
      StSend: begin
        // Entry required col_r beats present, so reads never underflow.
        rd_en = 1'b1;
        if (col_last) begin
          col_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          col_cnt_d = col_cnt_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          if (row_cnt_q + 16'd1 == rows_r_q) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 16'd1;
            state_d   = StFill;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      col_r_q      <= '0;
      rows_r_q     <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      row_end_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_r_q      <= col_r_d;
      rows_r_q     <= rows_r_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= rd_en;
      row_end_q    <= rd_en && col_last;
      frame_done_q <= frame_done_d;
    end
  end

  assign stream.out_valid = out_valid_q;
  assign stream.row_end   = row_end_q;
  assign frame_done       = frame_done_q;
  assign cfg_err          = cfg_err_q;

  assert property (@(posedge clk) disable iff (rst) rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_pool_row_feeder.sv
// Self-checking bench for pool_row_feeder (DEPTH=8, GAP=3). A row-level model predicts, per
// cycle, every output from the accepted-beat history: a row starts at the later of
// (3 cycles after its last beat was accepted) and (gap/start bound), then runs col beats.
module tb_pool_row_feeder;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned GAP    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_col = '0;
  logic [15:0] cfg_rows = '0;
  logic        frame_done, busy, cfg_err;

  pool_row_feeder_if #(.DATA_W(DATA_W)) sif ();

  pool_row_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP    (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_col    (cfg_col),
    .cfg_rows   (cfg_rows),
    .stream     (sif.slave),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] acc_data [$];
  int                acc_cyc  [$];
  int                col_m = 0, rows_left = 0, bound = 0, fd_cycle = -1, beat = 0, out_seen = 0;
  bit                in_row = 1'b0, busy_exp = 1'b0, cfg_err_exp = 1'b0;
  logic [DATA_W-1:0] last_data = '0;

  // Driver controls
  int drv_left = 0, drv_mode = 0, ph = 0, seq = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic mon_step();
    logic e_valid, e_row_end, e_fd, e_ready;
    int   ready_at;
    e_valid = 1'b0; e_row_end = 1'b0; e_fd = 1'b0;
    if (fd_cycle == cyc) begin
      busy_exp = 1'b0;
      e_fd     = 1'b1;
    end
    if (!in_row && rows_left > 0 && acc_data.size() >= col_m) begin
      ready_at = acc_cyc[col_m-1] + 3;
      if (cyc >= bound && cyc >= ready_at) begin
        in_row = 1'b1;
        beat   = 0;
      end
    end
    if (in_row) begin
      e_valid   = 1'b1;
      last_data = acc_data.pop_front();
      void'(acc_cyc.pop_front());
      e_row_end = (beat == col_m - 1);
      beat++;
      out_seen++;
      if (beat == col_m) begin
        in_row = 1'b0;
        rows_left--;
        bound = cyc + GAP + 2;
        if (rows_left == 0) fd_cycle = cyc + GAP;
      end
    end
    e_ready = busy_exp && (acc_data.size() < DEPTH);

    check("out_valid",  DATA_W'(sif.out_valid), DATA_W'(e_valid));
    check("out_data",   sif.out_data,           last_data);
    check("row_end",    DATA_W'(sif.row_end),   DATA_W'(e_row_end));
    check("frame_done", DATA_W'(frame_done),    DATA_W'(e_fd));
    check("busy",       DATA_W'(busy),          DATA_W'(busy_exp));
    check("in_ready",   DATA_W'(sif.in_ready),  DATA_W'(e_ready));
    check("cfg_err",    DATA_W'(cfg_err),       DATA_W'(cfg_err_exp));

    if (sif.in_valid && e_ready) begin
      acc_data.push_back(sif.in_data);
      acc_cyc.push_back(cyc);
    end
    if (start && !busy_exp) begin
      if (cfg_col == 0 || cfg_col > DEPTH || cfg_rows == 0) begin
        cfg_err_exp = 1'b1;
      end else begin
        cfg_err_exp = 1'b0;
        busy_exp    = 1'b1;
        col_m       = int'(cfg_col);
        rows_left   = int'(cfg_rows);
        bound       = cyc + 3;
        fd_cycle    = -1;
      end
    end
    if (rst) begin
      acc_data.delete();
      acc_cyc.delete();
      in_row = 1'b0; rows_left = 0; busy_exp = 1'b0; cfg_err_exp = 1'b0;
      last_data = '0; fd_cycle = -1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) mon_step();
  end

  // Beat driver: 0 = always valid, 1 = pattern 1,0,0,1, 2 = random ~60%.
  initial begin
    logic              hs, v;
    logic [3:0]        pat;
    logic [DATA_W-1:0] d;
    pat = 4'b1001;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    forever begin
      @(negedge clk);
      hs = sif.in_valid && sif.in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        drv_left--;
        seq++;
      end
      if (!(sif.in_valid && !hs && drv_left > 0)) begin
        v = 1'b0;
        if (drv_left > 0) begin
          case (drv_mode)
            0:       v = 1'b1;
            1:       v = pat[ph % 4];
            default: v = ($urandom_range(0, 99) < 60);
          endcase
          ph++;
        end
        sif.in_valid = v;
        if (v) begin
          for (int k = 1; k < 8; k++) d[k*32 +: 32] = $urandom;
          d[31:0] = seq;
          sif.in_data = d;
        end
      end
    end
  end

  task automatic start_frame(input int col, input int rows);
    @(posedge clk); #1;
    start    = 1'b1;
    cfg_col  = 16'(col);
    cfg_rows = 16'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int mode);
    @(posedge clk); #2;
    drv_mode = mode;
    drv_left = n;
    ph       = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      if (!busy_exp) done = 1'b1;
    end
    check("frame_timeout", DATA_W'(done), DATA_W'(1));
  endtask

  task automatic wait_beats(input int target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      if (out_seen >= target) done = 1'b1;
    end
    check("beat_timeout", DATA_W'(done), DATA_W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int col, rows, extra, mode;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Continuous input, two rows of 4
    start_frame(4, 2); feed(8, 0); wait_idle();
    // Bursty 1,0,0,1 input, rows of 6
    start_frame(6, 2); feed(12, 1); wait_idle();
    // Full-depth rows with input held valid: FIFO saturates
    start_frame(8, 3); feed(24, 0); wait_idle();
    // Config errors, then a valid start clears the flag
    start_frame(0, 1); repeat (2) @(posedge clk);
    start_frame(DEPTH + 1, 1);
    start_frame(3, 0);
    start_frame(2, 1); feed(2, 0); wait_idle();
    // Reset on the third beat of a 5-beat row, then a fresh frame
    start_frame(5, 1); feed(5, 0);
    wait_beats(out_seen + 2);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    start_frame(5, 1); feed(5, 0); wait_idle();
    // Start during SEND is ignored
    start_frame(3, 3); feed(9, 2);
    wait_beats(out_seen + 1);
    #1 start = 1'b1; cfg_col = 16'd2; cfg_rows = 16'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    // Random frames; surplus beats carry over to the next frame
    for (int f = 0; f < 12; f++) begin
      col   = $urandom_range(1, DEPTH);
      rows  = $urandom_range(1, 3);
      extra = $urandom_range(0, 2);
      mode  = $urandom_range(0, 2);
      start_frame(col, rows); feed(col * rows + extra, mode); wait_idle();
    end
    repeat (8) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
